hps_spi_bridge: RTL and testbench
=================================

# hps_spi_bridge

Parametrised HPS↔FPGA SPI command bridge, the next generation of the system-level HPS interface. It is a mode-0 SPI slave oversampled in `clk_sys`, with configurable word width. The first word of every chip-select frame can optionally return a status word carrying the enable lines. Received words are delivered to the core either as a one-cycle strobe or, with the FIFO option, through a valid/ready queue with overrun detection.

## Interface
- `WORD_W`, 16: SPI word width; legal 16..32.
- `STATUS_FIRST`, 1: when 1, the first MISO word of each frame is the status word; when 0, every word comes from `tx_word`.
- `FIFO_DEPTH`, 4: RX FIFO entries, power of two ≥2; only used with `HPS_SPI_RXFIFO_EN`.
- `clk_sys`  in  1  system clock; all logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_clk`, `spi_mosi`  in  1  HPS SPI clock and data; asynchronous to `clk_sys`.
- `spi_cs`  in  1  chip select, active-low; asynchronous to `clk_sys`.
- `spi_miso`  out  1  serial data to the HPS.
- `fpga_enable`, `osd_enable`, `io_enable`  in  1  HPS status lines.
- `tx_word`  in  WORD_W  next word to shift out.
- `rx_word`  out  WORD_W  received word, or the FIFO head.
- `rx_first`  out  1  marks `rx_word` as the first word of its frame.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts the word; ignored without the FIFO.
- `io_strobe`  out  1  one-cycle pulse per completed word, regardless of the FIFO option.
- `status`  out  3  registered `{io_enable, osd_enable, fpga_enable}`.
- `overrun`  out  1  sticky flag: a word was dropped.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- `spi_clk`, `spi_cs`, `spi_mosi` each pass through a 2-flop synchroniser. The synchronised `spi_clk` then feeds a third flop for edge detection.
- Frame start: synchronised `spi_cs` falls.
  - `bit_cnt` is set to 0 and `first` is set to 1.
  - The TX shift register loads `status_word` if `STATUS_FIRST`, otherwise `tx_word`.
- `status_word` layout:
  - bits [7:0] = `IF_VERSION`;
  - bits [10:8] = `{io_enable, osd_enable, fpga_enable}`;
  - upper bits = 0.
- Word format: MSB first, mode 0.
- Rising edge of `spi_clk` (detected, `spi_cs` low):
  - shift `spi_mosi` into the RX register;
  - increment `bit_cnt`.
- Falling edge of `spi_clk` (detected): the TX register shifts left. `spi_miso` is always the TX register MSB.
- Word complete: a rising edge with `bit_cnt == WORD_W-1`. On completion:
  - `bit_cnt` wraps to 0;
  - the RX word and `first` are committed to the output stage;
  - `first` clears;
  - the TX register reloads from `tx_word`, sampled on the same cycle.
- Frame end: `spi_cs` rises mid-word.
  - The partial word is discarded: no strobe, no FIFO push.
  - `bit_cnt` is set to 0.
- While `spi_cs` is high, `spi_clk` edges are ignored and `spi_miso` is driven to 0.
- `status` is re-registered every cycle.
- Output stage without the FIFO:
  - `rx_word`/`rx_first` update on completion and hold until the next one;
  - `rx_valid` equals `io_strobe`;
  - `overrun` is constant 0.
- Reset values: all registers 0. In particular `spi_miso`, `rx_word`, `rx_first`, `rx_valid`, `io_strobe`, `overrun`, `status` are all 0.
- Asserting `reset_n` mid-frame aborts the frame. After release, the block waits for a fresh `spi_cs` falling edge; a frame already in progress is ignored until CS toggles.

## Timing
- SPI clock must satisfy `f_spi_clk ≤ f_clk_sys/6`. The `spi_clk` high and low times must each be ≥3 `clk_sys` cycles.
- Detection latency: 3 cycles from a pin edge to the internal edge pulse.
- `io_strobe` and the registered `rx_word` arrive 1 cycle after the internal last-bit rising-edge pulse.
- The FIFO push happens in the `io_strobe` cycle. `rx_valid` rises the next cycle.
- `spi_miso` changes 1 cycle after the internal falling-edge pulse. The first bit (MSB) is valid 1 cycle after CS-fall detection.
- `overrun_clr` takes effect in the next cycle. If it is asserted in the same cycle as a new drop, `overrun` ends up set (the set wins).

## Configuration
- `HPS_SPI_RXFIFO_EN` defined:
  - A FIFO_DEPTH × (WORD_W+1) queue holds `{first, word}`.
  - `rx_valid` means the FIFO is not empty. A pop happens when `rx_valid && rx_ready`.
  - A push while full is dropped and sets `overrun`. A push while full with a pop in the same cycle is accepted.
  - While the FIFO is empty, `rx_word` holds its last value.
- `HPS_SPI_RXFIFO_EN` undefined: single output register as described under Operation. `rx_ready` and `overrun_clr` are unused.

## Structure
- Package `hps_spi_pkg` holds:
  - `IF_VERSION` = 8'h02;
  - the status bit positions `ST_FPGA`=8, `ST_OSD`=9, `ST_IO`=10;
  - the frame-state enum `IDLE`/`SHIFT`.
- Sub-module `hps_spi_rx_fifo` is a synchronous FIFO with `WIDTH` and `DEPTH` parameters and count-based full/empty. It is instantiated only under the macro.

## Test plan
- WORD_W=16, STATUS_FIRST=1, enables=3'b101, one frame sending 16'hA55A, 16'h1234, `tx_word`=16'hBEEF:
  - MISO returns 16'h0502, then 16'hBEEF;
  - `rx_word` gives A55A with `rx_first`=1, then 1234 with `rx_first`=0;
  - exactly 2 `io_strobe` pulses.
- CS rises after 9 bits, then a new frame sends 16'h00FF: no strobe for the partial word; the next word is 00FF with `rx_first`=1.
- WORD_W=32, STATUS_FIRST=0, sending 32'hDEADBEEF with `tx_word`=32'h0BADF00D: `rx_word`=DEADBEEF and MISO returns 0BADF00D.
- FIFO_DEPTH=4, `rx_ready`=0, 5 words sent: `rx_valid`=1, `overrun`=1, and words 1–4 drain in order; `overrun_clr` then returns `overrun` to 0.
- FIFO full with `rx_ready`=1 during the 5th word's push: the 5th word is accepted and `overrun` stays 0.
- `reset_n` pulsed low mid-word: all outputs read 0 and `spi_miso`=0; no strobe occurs until CS is deasserted and reasserted.

Source files
------------

// File: rtl/hps_spi_pkg.sv
// hps_spi_pkg
//   Shared constants and types for the HPS<->FPGA SPI command bridge.
//   IF_VERSION         : interface revision reported in the status word
//   ST_FPGA/ST_OSD/ST_IO : bit positions of the enable lines in the status word
//   frame_state_e      : chip-select frame state (IDLE / SHIFT)
package hps_spi_pkg;

    localparam logic [7:0] IF_VERSION = 8'h02;

    localparam int ST_FPGA = 8;
    localparam int ST_OSD  = 9;
    localparam int ST_IO   = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/hps_spi_rx_fifo.sv
// hps_spi_rx_fifo
//   Synchronous FIFO with count-based full/empty. DEPTH must be a power of
//   two >= 2 so the pointers wrap naturally.
//   clk_sys, reset_n : clock, async active-low reset
//   push, push_data  : write request / data (ignored while full unless popping)
//   pop              : read request (ignored while empty)
//   head             : entry at the read pointer
//   full, empty      : occupancy flags
module hps_spi_rx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic                        do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue still lands when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hps_spi_bridge.sv
// hps_spi_bridge
//   Mode-0 SPI slave oversampled in clk_sys. Received words go to the core as
//   a one-cycle strobe, or (HPS_SPI_RXFIFO_EN defined) through a valid/ready
//   FIFO with a sticky overrun flag. The first MISO word of each frame can be
//   a status word carrying IF_VERSION and the enable lines.
//   Optional feature macro: HPS_SPI_RXFIFO_EN
//   Ports:
//     clk_sys, reset_n          : system clock, async active-low reset
//     spi_clk/spi_mosi/spi_cs   : async SPI inputs (cs active low)
//     spi_miso                  : serial data out, 0 outside a frame
//     fpga/osd/io_enable        : status lines
//     tx_word                   : next word to shift out
//     rx_word/rx_first/rx_valid : received word, first-of-frame flag, valid
//     rx_ready                  : consumer ready (FIFO build only)
//     io_strobe                 : pulse per completed word
//     status                    : registered {io, osd, fpga} enables
//     overrun / overrun_clr     : sticky drop flag and its clear
module hps_spi_bridge
    import hps_spi_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter bit STATUS_FIRST = 1'b1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    input  logic              fpga_enable,
    input  logic              osd_enable,
    input  logic              io_enable,
    input  logic [WORD_W-1:0] tx_word,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_first,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              io_strobe,
    output logic [2:0]        status,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef struct packed {
        logic              first;
        logic [WORD_W-1:0] word;
    } rx_ent_t;

    // ---- synchronisers and edge detectors ----
    logic [1:0] clk_sync, cs_sync, mosi_sync;
    logic       clk_d, cs_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            clk_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            clk_d     <= clk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    // cs_d resets low, so a frame already in progress at reset release never
    // produces a falling edge; the block waits for CS to toggle.
    logic cs_fall;
    assign cs_fall = cs_d && !cs_sync[1];

    // ---- frame FSM ----
    frame_state_e state, state_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall)    state_nxt = SHIFT;
            SHIFT:   if (cs_sync[1]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic in_frame, frame_start, frame_abort, sclk_rise, sclk_fall, word_done;

    assign in_frame    = (state == SHIFT) && !cs_sync[1];
    assign frame_start = (state == IDLE) && cs_fall;
    assign frame_abort = (state == SHIFT) && cs_sync[1];
    assign sclk_rise   = in_frame && clk_sync[1] && !clk_d;
    assign sclk_fall   = in_frame && !clk_sync[1] && clk_d;

    // ---- shift registers ----
    logic [CNT_W-1:0]  bit_cnt;
    logic              first;
    logic [WORD_W-2:0] rx_sr;
    logic [WORD_W-1:0] tx_sr;
    logic [WORD_W-1:0] rx_next;
    logic [WORD_W-1:0] status_word;

    assign word_done = sclk_rise && (bit_cnt == LAST_BIT);
    assign rx_next   = {rx_sr, mosi_sync[1]};

    always_comb begin
        status_word          = '0;
        status_word[7:0]     = IF_VERSION;
        status_word[ST_FPGA] = status[0];
        status_word[ST_OSD]  = status[1];
        status_word[ST_IO]   = status[2];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            first   <= 1'b0;
            rx_sr   <= '0;
            tx_sr   <= '0;
        end else if (frame_start) begin
            bit_cnt <= '0;
            first   <= 1'b1;
            tx_sr   <= STATUS_FIRST ? status_word : tx_word;
        end else if (frame_abort) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            rx_sr <= rx_next[WORD_W-2:0];
            if (word_done) begin
                bit_cnt <= '0;
                first   <= 1'b0;
                tx_sr   <= tx_word;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (sclk_fall && bit_cnt != '0) begin
            // The falling edge that closes a word (bit_cnt back at 0) must not
            // shift: the freshly reloaded MSB is the next word's first bit.
            tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
        end
    end

    assign spi_miso = in_frame ? tx_sr[WORD_W-1] : 1'b0;

    // ---- capture stage ----
    rx_ent_t cap;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io_strobe <= 1'b0;
            cap       <= '0;
            status    <= '0;
        end else begin
            io_strobe <= word_done;
            status    <= {io_enable, osd_enable, fpga_enable};
            if (word_done) begin
                cap.first <= first;
                cap.word  <= rx_next;
            end
        end
    end

`ifdef HPS_SPI_RXFIFO_EN
    rx_ent_t fifo_head, hold_q;
    logic    fifo_full, fifo_empty, fifo_pop, fifo_drop, overrun_q;

    assign rx_valid  = !fifo_empty;
    assign fifo_pop  = rx_valid && rx_ready;
    assign fifo_drop = io_strobe && fifo_full && !fifo_pop;

    hps_spi_rx_fifo #(
        .WIDTH ($bits(rx_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (io_strobe),
        .push_data (cap),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Remember the last popped entry so rx_word holds while the queue is empty.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (fifo_pop)
                hold_q <= fifo_head;
            if (fifo_drop)
                overrun_q <= 1'b1;
            else if (overrun_clr)
                overrun_q <= 1'b0;
        end
    end

    assign rx_word  = fifo_empty ? hold_q.word  : fifo_head.word;
    assign rx_first = fifo_empty ? hold_q.first : fifo_head.first;
    assign overrun  = overrun_q;
`else
    assign rx_word  = cap.word;
    assign rx_first = cap.first;
    assign rx_valid = io_strobe;
    assign overrun  = 1'b0;

    logic unused_cfg;
    assign unused_cfg = &{1'b0, rx_ready, overrun_clr, FIFO_DEPTH[0]};
`endif

endmodule

// File: tb/tb_hps_spi_bridge.sv
module tb_hps_spi_bridge;

    localparam int HALF = 8;   // clk_sys cycles per SPI clock phase

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n;
    logic        spi_clk, spi_mosi, cs16, cs32;
    logic        fpga_en, osd_en, io_en;
    logic [15:0] tx16, rxw16;
    logic [31:0] tx32, rxw32;
    logic        miso16, miso32;
    logic        rxf16, rxf32, rxv16, rxv32, rdy16, rdy32;
    logic        stb16, stb32, ovr16, ovr32, oclr16, oclr32;
    logic [2:0]  st16, st32;

    int n_assert = 0;
    int n_fail   = 0;

    hps_spi_bridge #(.WORD_W(16), .STATUS_FIRST(1'b1), .FIFO_DEPTH(4)) dut16 (
        .clk_sys(clk_sys), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs(cs16), .spi_miso(miso16), .fpga_enable(fpga_en), .osd_enable(osd_en),
        .io_enable(io_en), .tx_word(tx16), .rx_word(rxw16), .rx_first(rxf16),
        .rx_valid(rxv16), .rx_ready(rdy16), .io_strobe(stb16), .status(st16),
        .overrun(ovr16), .overrun_clr(oclr16)
    );

    hps_spi_bridge #(.WORD_W(32), .STATUS_FIRST(1'b0), .FIFO_DEPTH(4)) dut32 (
        .clk_sys(clk_sys), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs(cs32), .spi_miso(miso32), .fpga_enable(fpga_en), .osd_enable(osd_en),
        .io_enable(io_en), .tx_word(tx32), .rx_word(rxw32), .rx_first(rxf32),
        .rx_valid(rxv32), .rx_ready(rdy32), .io_strobe(stb32), .status(st32),
        .overrun(ovr32), .overrun_clr(oclr32)
    );

    // Accepted words and strobe pulses of the 16-bit instance, sampled mid-cycle.
    logic [16:0] q16[$];
    int          n_stb16 = 0;

    always @(negedge clk_sys) begin
        if (stb16) n_stb16 = n_stb16 + 1;
        if (rxv16 && rdy16) q16.push_back({rxf16, rxw16});
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [16:0] exp);
        logic [17:0] got;
        got = '0;
        if (q16.size() > 0) got = {1'b1, q16.pop_front()};
        chk(tag, 64'(got), 64'({1'b1, exp}));
    endtask

    task automatic cs_set(input int sel, input logic v);
        if (sel == 32) cs32 = v;
        else           cs16 = v;
        wait_cyc(HALF);
    endtask

    // Mode 0 master: drive MOSI while SCK low, sample MISO just before rising.
    task automatic send(input int sel, input int nbits, input logic [31:0] data,
                        output logic [31:0] got);
        got = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = data[i];
            wait_cyc(HALF);
            got = {got[30:0], (sel == 32) ? miso32 : miso16};
            spi_clk = 1'b1;
            wait_cyc(HALF);
            spi_clk = 1'b0;
        end
    endtask

    logic [31:0] m;
    int          s;
    logic        seen5;

    initial begin
        reset_n = 1'b0;
        spi_clk = 1'b0; spi_mosi = 1'b0; cs16 = 1'b1; cs32 = 1'b1;
        io_en = 1'b1; osd_en = 1'b0; fpga_en = 1'b1;
        tx16 = 16'hBEEF; tx32 = 32'h0BADF00D;
        rdy16 = 1'b1; rdy32 = 1'b1; oclr16 = 1'b0; oclr32 = 1'b0;
        seen5 = 1'b0;
        wait_cyc(3);

        // reset state
        chk("rst_rx_word",  64'(rxw16),  64'(16'h0000));
        chk("rst_rx_first", 64'(rxf16),  64'(1'b0));
        chk("rst_rx_valid", 64'(rxv16),  64'(1'b0));
        chk("rst_strobe",   64'(stb16),  64'(1'b0));
        chk("rst_overrun",  64'(ovr16),  64'(1'b0));
        chk("rst_status",   64'(st16),   64'(3'b000));
        chk("rst_miso",     64'(miso16), 64'(1'b0));
        reset_n = 1'b1;
        wait_cyc(4);
        chk("status_101",   64'(st16),   64'(3'b101));

        // two-word frame, status word first
        cs_set(16, 1'b0);
        send(16, 16, 32'hA55A, m);
        chk("miso_status",  64'(m), 64'(32'h0502));
        send(16, 16, 32'h1234, m);
        chk("miso_beef",    64'(m), 64'(32'hBEEF));
        cs_set(16, 1'b1);
        chk("two_strobes",  64'(n_stb16), 64'(2));
        chk_q("word1_a55a", {1'b1, 16'hA55A});
        chk_q("word2_1234", {1'b0, 16'h1234});
        chk("hold_1234",    64'(rxw16), 64'(16'h1234));
        chk("valid_low",    64'(rxv16), 64'(1'b0));

        // partial word discarded, next frame starts clean
        cs_set(16, 1'b0);
        send(16, 9, 32'h1AB, m);
        cs_set(16, 1'b1);
        chk("partial_nostb", 64'(n_stb16), 64'(2));
        chk("partial_hold",  64'(rxw16),   64'(16'h1234));
        cs_set(16, 1'b0);
        send(16, 16, 32'h00FF, m);
        chk("miso_status2",  64'(m), 64'(32'h0502));
        cs_set(16, 1'b1);
        chk("stb_after_00ff", 64'(n_stb16), 64'(3));
        chk_q("word_00ff",   {1'b1, 16'h00FF});

        // 32-bit word, no status word
        cs_set(32, 1'b0);
        send(32, 32, 32'hDEADBEEF, m);
        chk("miso32", 64'(m), 64'(32'h0BADF00D));
        cs_set(32, 1'b1);
        chk("rx_word32",  64'(rxw32), 64'(32'hDEADBEEF));
        chk("rx_first32", 64'(rxf32), 64'(1'b1));

`ifdef HPS_SPI_RXFIFO_EN
        // fill past depth with consumer stalled
        rdy16 = 1'b0;
        cs_set(16, 1'b0);
        for (int k = 1; k <= 5; k++) send(16, 16, 32'h1111 * k, m);
        cs_set(16, 1'b1);
        chk("fifo_stb5",    64'(n_stb16), 64'(8));
        chk("fifo_valid",   64'(rxv16),   64'(1'b1));
        chk("fifo_overrun", 64'(ovr16),   64'(1'b1));
        chk("fifo_head",    64'(rxw16),   64'(16'h1111));
        rdy16 = 1'b1;
        wait_cyc(6);
        rdy16 = 1'b0;
        chk_q("drain_1111", {1'b1, 16'h1111});
        chk_q("drain_2222", {1'b0, 16'h2222});
        chk_q("drain_3333", {1'b0, 16'h3333});
        chk_q("drain_4444", {1'b0, 16'h4444});
        chk("drained_empty", 64'(rxv16), 64'(1'b0));
        chk("empty_hold",    64'(rxw16), 64'(16'h4444));
        oclr16 = 1'b1;
        wait_cyc(1);
        oclr16 = 1'b0;
        chk("overrun_clr",   64'(ovr16), 64'(1'b0));

        // full FIFO, pop coincides with the 5th push
        cs_set(16, 1'b0);
        for (int k = 1; k <= 4; k++) send(16, 16, 32'hA000 + k, m);
        fork
            send(16, 16, 32'hA005, m);
            begin
                for (int k = 0; k < 1000; k++) begin
                    @(posedge clk_sys); #1;
                    if (stb16) begin seen5 = 1'b1; break; end
                end
                rdy16 = 1'b1;
                wait_cyc(1);
                rdy16 = 1'b0;
            end
        join
        cs_set(16, 1'b1);
        chk("push5_seen",   64'(seen5),   64'(1'b1));
        chk("full_pop_ovr", 64'(ovr16),   64'(1'b0));
        chk("full_pop_stb", 64'(n_stb16), 64'(13));
        chk_q("pop_a001",   {1'b1, 16'hA001});
        rdy16 = 1'b1;
        wait_cyc(6);
        chk_q("drain_a002", {1'b0, 16'hA002});
        chk_q("drain_a003", {1'b0, 16'hA003});
        chk_q("drain_a004", {1'b0, 16'hA004});
        chk_q("drain_a005", {1'b0, 16'hA005});
`endif

        // reset mid-word aborts the frame until CS toggles
        rdy16 = 1'b1;
        cs_set(16, 1'b0);
        send(16, 5, 32'h15, m);
        reset_n = 1'b0;
        wait_cyc(2);
        chk("mid_rst_word",   64'(rxw16),  64'(16'h0000));
        chk("mid_rst_first",  64'(rxf16),  64'(1'b0));
        chk("mid_rst_valid",  64'(rxv16),  64'(1'b0));
        chk("mid_rst_strobe", 64'(stb16),  64'(1'b0));
        chk("mid_rst_ovr",    64'(ovr16),  64'(1'b0));
        chk("mid_rst_status", 64'(st16),   64'(3'b000));
        chk("mid_rst_miso",   64'(miso16), 64'(1'b0));
        reset_n = 1'b1;
        wait_cyc(3);
        chk("post_rst_miso",  64'(miso16), 64'(1'b0));
        s = n_stb16;
        send(16, 16, 32'hFFFF, m);
        chk("stale_miso",     64'(m),       64'(32'h0));
        chk("stale_nostb",    64'(n_stb16), 64'(s));
        cs_set(16, 1'b1);
        cs_set(16, 1'b0);
        send(16, 16, 32'hC0DE, m);
        chk("fresh_miso",     64'(m), 64'(32'h0502));
        cs_set(16, 1'b1);
        chk("fresh_stb",      64'(n_stb16), 64'(s + 1));
        chk_q("fresh_c0de",   {1'b1, 16'hC0DE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
